// File: rtl/and_n_qualified.sv
// rtl/and_n_qualified.sv - N-input AND with input synchronisers, qualification filter and edge pulses
module and_n_qualified #(
    parameter int N           = 3,
    parameter int QUAL        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int INVERT      = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] in,
    output logic         y,
    output logic         y_rise,
    output logic         y_fall,
    output logic         raw
);

    localparam int CW = $clog2(QUAL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(QUAL - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;
    localparam logic INV = (INVERT != 0);

    logic [N-1:0]  in_s;
    logic [0:0]    q_state;
    logic [CW-1:0] cnt;
    logic          disagree;
    logic          last_sample;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign in_s = in;
        end else begin : g_sync
            logic [N-1:0] stage [SYNC_STAGES];

            // Synchroniser chain; keeps clocking even while qualification is frozen
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign in_s = stage[SYNC_STAGES-1];
        end
    endgenerate

    assign raw         = &in_s;
    assign disagree    = (raw != q_state[0]);
    assign last_sample = (cnt == CNT_LAST);

    // Qualification: a disagreement must persist for QUAL enabled samples before
    // the state flips; any agreeing sample throws the partial run away
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_state <= ST_LOW;
            cnt     <= '0;
            y_rise  <= 1'b0;
            y_fall  <= 1'b0;
        end else begin
            y_rise <= 1'b0;
            y_fall <= 1'b0;
            if (en) begin
                if (!disagree) begin
                    cnt <= '0;
                end else if (last_sample) begin
                    cnt     <= '0;
                    q_state <= (q_state == ST_HIGH) ? ST_LOW : ST_HIGH;
                    y_rise  <= (q_state == ST_LOW);
                    y_fall  <= (q_state == ST_HIGH);
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    assign y = q_state[0] ^ INV;

endmodule

// File: tb/tb_and_n_qualified.sv
// tb/tb_and_n_qualified.sv - self-checking bench for and_n_qualified
module tb_and_n_qualified;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_c;
    logic       en_a, en_b, en_c;
    logic       y_a, y_rise_a, y_fall_a, raw_a;
    logic       y_b, y_rise_b, y_fall_b, raw_b;
    logic       y_c, y_rise_c, y_fall_c, raw_c;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    and_n_qualified dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .in(in_a),
        .y(y_a), .y_rise(y_rise_a), .y_fall(y_fall_a), .raw(raw_a)
    );

    and_n_qualified #(.N(8), .QUAL(5), .SYNC_STAGES(0), .INVERT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .in(in_b),
        .y(y_b), .y_rise(y_rise_b), .y_fall(y_fall_b), .raw(raw_b)
    );

    and_n_qualified #(.N(3), .QUAL(1), .SYNC_STAGES(0), .INVERT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .in(in_c),
        .y(y_c), .y_rise(y_rise_c), .y_fall(y_fall_c), .raw(raw_c)
    );

    // Reference: the input delayed by a plain sample history, and the qualified
    // state flips once a run of QUAL disagreeing enabled samples has been seen.
    typedef struct packed {
        int              run;
        logic            state;
        logic            rise;
        logic            fall;
        logic [2:0][15:0] hist;
    } model_t;

    model_t ma = '0;
    model_t mb = '0;
    model_t mc = '0;

    function automatic logic and_n(input logic [15:0] v, input int n);
        logic r = 1'b1;
        for (int i = 0; i < n; i++) r &= v[i];
        return r;
    endfunction

    function automatic model_t step(input model_t m, input logic [15:0] v, input logic e,
                                    input logic rs, input int n, input int qual, input int s);
        model_t o = m;
        logic r;
        if (!rs) begin
            o.run = 0; o.state = 1'b0; o.rise = 1'b0; o.fall = 1'b0; o.hist = '0;
            return o;
        end
        r = (s == 0) ? and_n(v, n) : and_n(o.hist[0], n);
        for (int i = 0; i < s - 1; i++) o.hist[i] = o.hist[i+1];
        if (s > 0) o.hist[s-1] = v;
        o.rise = 1'b0;
        o.fall = 1'b0;
        if (e) begin
            if (r == o.state) begin
                o.run = 0;
            end else begin
                o.run = o.run + 1;
                if (o.run == qual) begin
                    o.state = ~o.state;
                    o.run   = 0;
                    o.rise  = o.state;
                    o.fall  = ~o.state;
                end
            end
        end
        return o;
    endfunction

    task automatic tick;
        @(posedge clk);
        ma = step(ma, 16'(in_a), en_a, rst_n, 3, 4, 2);
        mb = step(mb, 16'(in_b), en_b, rst_n, 8, 5, 0);
        mc = step(mc, 16'(in_c), en_c, rst_n, 3, 1, 0);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_a = '0; in_b = '0; in_c = '0;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        tick(); tick();
        total_cnt++;
        if ({y_a, y_rise_a, y_fall_a, raw_a} !== 4'b0000) $display("FAIL reset_a got=%b exp=0000", {y_a, y_rise_a, y_fall_a, raw_a});
        else pass_cnt++;
        total_cnt++;
        if ({y_b, y_rise_b, y_fall_b} !== 3'b100) $display("FAIL reset_b got=%b exp=100", {y_b, y_rise_b, y_fall_b});
        else pass_cnt++;
        total_cnt++;
        if ({y_c, y_rise_c, y_fall_c} !== 3'b000) $display("FAIL reset_c got=%b exp=000", {y_c, y_rise_c, y_fall_c});
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({y_a, y_rise_a, y_fall_a, raw_a, y_b, y_rise_b, y_fall_b} !== 7'b0000100)
            $display("FAIL reset_exit got=%b exp=0000100", {y_a, y_rise_a, y_fall_a, raw_a, y_b, y_rise_b, y_fall_b});
        else pass_cnt++;
    endtask

    task automatic test_rise_fall;
        int first;
        int rises, falls;
        do_reset();
        tick();
        for (int phase = 0; phase < 2; phase++) begin
            in_a  = (phase == 0) ? 3'b111 : 3'b101;
            first = 0; rises = 0; falls = 0;
            for (int e = 1; e <= 12; e++) begin
                tick();
                total_cnt++;
                if ({y_a, y_rise_a, y_fall_a} !== {ma.state, ma.rise, ma.fall})
                    $display("FAIL rise_fall_edge%0d got=%b exp=%b", e, {y_a, y_rise_a, y_fall_a}, {ma.state, ma.rise, ma.fall});
                else pass_cnt++;
                if (first == 0 && y_a == (phase == 0)) first = e;
                rises += int'(y_rise_a);
                falls += int'(y_fall_a);
            end
            total_cnt++;
            if (first != 6) $display("FAIL latency_phase%0d got=%0d exp=6", phase, first);
            else pass_cnt++;
            total_cnt++;
            if (rises != (phase == 0 ? 1 : 0) || falls != (phase == 0 ? 0 : 1))
                $display("FAIL pulse_count_phase%0d got rise=%0d fall=%0d", phase, rises, falls);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch;
        logic saw_raw;
        in_a = 3'b000;
        do_reset();
        tick(); tick();
        saw_raw = 1'b0;
        in_a = 3'b111;
        for (int e = 1; e <= 11; e++) begin
            if (e == 4) in_a = 3'b011;
            tick();
            saw_raw |= raw_a;
            total_cnt++;
            if ({y_a, y_rise_a, y_fall_a} !== 3'b000)
                $display("FAIL glitch_edge%0d got=%b exp=000", e, {y_a, y_rise_a, y_fall_a});
            else pass_cnt++;
        end
        total_cnt++;
        if (saw_raw !== 1'b1 || raw_a !== 1'b0) $display("FAIL glitch_raw saw=%b final=%b exp saw=1 final=0", saw_raw, raw_a);
        else pass_cnt++;
    endtask

    task automatic test_enable;
        int enabled, drop_at;
        in_b = 8'h00;
        en_b = 1'b1;
        do_reset();
        in_b = 8'hFF;
        enabled = 0; drop_at = 0;
        for (int k = 1; k <= 14; k++) begin
            en_b = (k % 2 == 1);
            if (en_b) enabled++;
            tick();
            total_cnt++;
            if ({y_b, y_rise_b, y_fall_b, raw_b} !== {~mb.state, mb.rise, mb.fall, 1'b1})
                $display("FAIL enable_edge%0d got=%b exp=%b", k, {y_b, y_rise_b, y_fall_b, raw_b}, {~mb.state, mb.rise, mb.fall, 1'b1});
            else pass_cnt++;
            if (drop_at == 0 && y_b == 1'b0) begin
                drop_at = enabled;
                total_cnt++;
                if (y_rise_b !== 1'b1) $display("FAIL enable_pulse got=%b exp=1", y_rise_b);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (drop_at != 5) $display("FAIL enable_latency got=%0d exp=5", drop_at);
        else pass_cnt++;
        en_b = 1'b1;
    endtask

    task automatic test_reset_midcount;
        int first;
        in_a = 3'b000;
        do_reset();
        in_a = 3'b111;
        for (int e = 0; e < 4; e++) tick();
        rst_n = 1'b0;
        for (int e = 0; e < 2; e++) begin
            tick();
            total_cnt++;
            if ({y_a, y_rise_a, y_fall_a, raw_a} !== 4'b0000)
                $display("FAIL midreset_hold%0d got=%b exp=0000", e, {y_a, y_rise_a, y_fall_a, raw_a});
            else pass_cnt++;
        end
        rst_n = 1'b1;
        first = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (first == 0 && y_a) first = e;
        end
        total_cnt++;
        if (first != 6) $display("FAIL midreset_latency got=%0d exp=6", first);
        else pass_cnt++;
    endtask

    task automatic test_alternate;
        in_c = 3'b000;
        en_c = 1'b1;
        do_reset();
        tick();
        for (int k = 1; k <= 10; k++) begin
            in_c = (k % 2 == 1) ? 3'b111 : 3'b000;
            tick();
            total_cnt++;
            if ({y_c, y_rise_c, y_fall_c} !== {k % 2 == 1, k % 2 == 1, k % 2 == 0})
                $display("FAIL alternate_edge%0d got=%b exp=%b", k, {y_c, y_rise_c, y_fall_c}, {k % 2 == 1, k % 2 == 1, k % 2 == 0});
            else pass_cnt++;
        end
    endtask

    task automatic test_random;
        int errs;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            in_a  = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom);
            in_b  = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom);
            in_c  = 3'($urandom);
            en_a  = ($urandom_range(0, 9) != 0);
            en_b  = ($urandom_range(0, 3) != 0);
            en_c  = ($urandom_range(0, 3) != 0);
            tick();
            total_cnt++;
            if ({y_a, y_rise_a, y_fall_a, raw_a} !== {ma.state, ma.rise, ma.fall, and_n(ma.hist[0], 3)}) begin
                if (errs < 10) $display("FAIL random_a cyc=%0d got=%b exp=%b", k, {y_a, y_rise_a, y_fall_a, raw_a}, {ma.state, ma.rise, ma.fall, and_n(ma.hist[0], 3)});
                errs++;
            end else pass_cnt++;
            total_cnt++;
            if ({y_b, y_rise_b, y_fall_b, raw_b} !== {~mb.state, mb.rise, mb.fall, &in_b}) begin
                if (errs < 10) $display("FAIL random_b cyc=%0d got=%b exp=%b", k, {y_b, y_rise_b, y_fall_b, raw_b}, {~mb.state, mb.rise, mb.fall, &in_b});
                errs++;
            end else pass_cnt++;
            total_cnt++;
            if ({y_c, y_rise_c, y_fall_c, raw_c} !== {mc.state, mc.rise, mc.fall, &in_c}) begin
                if (errs < 10) $display("FAIL random_c cyc=%0d got=%b exp=%b", k, {y_c, y_rise_c, y_fall_c, raw_c}, {mc.state, mc.rise, mc.fall, &in_c});
                errs++;
            end else pass_cnt++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_glitch();
        test_enable();
        test_reset_midcount();
        test_alternate();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/and_n_qualified.md
# and_n_qualified

Parametrised N-input AND gate with per-input synchronisers, a consecutive-sample qualification filter on both edges, optional inverted (NAND) output, and single-cycle edge pulses. It is the sequential successor to the fixed 3-input combinational AND. It is used where the video terminal combines asynchronous or glitchy TTL-style conditions (keyboard strobe, data-available, ready lines) into one clean, clock-domain-safe level plus event pulses.

## Interface
- N, 3: number of inputs, 1..16.
- QUAL, 4: consecutive agreeing samples required to change state, 1..255.
- SYNC_STAGES, 2: synchroniser flops per input, 0..3; 0 = inputs already synchronous.
- INVERT, 0: 1 = `y` is the NAND of the qualified value, 0 = AND.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  qualification enable; low freezes counter and state.
- in  in  N  raw inputs, may be asynchronous.
- y  out  1  qualified level: `q_state ^ INVERT`.
- y_rise  out  1  one-cycle pulse when `q_state` goes 0→1.
- y_fall  out  1  one-cycle pulse when `q_state` goes 1→0.
- raw  out  1  unfiltered AND of synchronised inputs, for debug. Combinational from sync flops; equals `&in` when SYNC_STAGES=0.

## Operation
- Sync chain: each `in[i]` passes SYNC_STAGES flops, giving `in_s`. The chain always clocks and ignores `en`.
- `raw = &in_s`.
- `q_state` has two states:
  - LOW (AND not qualified): reset state.
  - HIGH (AND qualified).
- Counter `cnt`, width clog2(QUAL+1), counts consecutive enabled samples where `raw != q_state`.
- On each edge with `en`=1:
  - If `raw == q_state`: `cnt` ← 0.
  - Else if `cnt == QUAL-1`: `q_state` toggles, `cnt` ← 0, and the matching pulse (`y_rise` or `y_fall`) is 1 for that cycle.
  - Else: `cnt` increments.
- Any disagreement run shorter than QUAL samples is discarded; `cnt` restarts from 0 when `raw` returns to `q_state`.
- `en`=0: `cnt` and `q_state` hold; `y_rise`/`y_fall` are 0. A run interrupted by `en` low resumes counting from the held `cnt`.
- QUAL=1: state follows `raw` with one registered cycle, with no filtering.
- `y_rise` and `y_fall` are registered, mutually exclusive, and never asserted on consecutive cycles when QUAL≥2.
- Reset (`rst_n`=0 at an edge), including mid-count:
  - Sync flops ← 0, `cnt` ← 0, `q_state` ← LOW.
  - `y_rise` ← 0, `y_fall` ← 0.
  - `y` ← INVERT.
  - No pulse is emitted on reset entry or exit.

## Timing
- Reset values: `y`=INVERT, `y_rise`=0, `y_fall`=0, `raw`=0 when SYNC_STAGES≥1.
- Latency is counted in rising edges with `en`=1, starting at the first edge at which the new input value is stable at `in`. `y` and the pulse update after edge number SYNC_STAGES+QUAL.
  - Defaults: 6 edges.
  - SYNC_STAGES=0, QUAL=1: 1 edge.
- The pulse is high for exactly the one cycle following the edge on which `y` changes.
- Throughput: a new transition can be qualified QUAL edges after the previous one.
- Reset takes effect at the edge sampling `rst_n`=0. Qualification restarts from zero on the first edge after `rst_n` returns high.

## Test plan
- Defaults; all `in` 0→1 held → `y` rises after edge 6, `y_rise`=1 for one cycle, `y_fall` stays 0. Then `in[1]` 1→0 held → `y` falls after 6 edges, `y_fall` pulses once.
- Defaults; `in`=3'b111 for 3 cycles then 3'b011 → `raw` toggles, `y` stays 0, no pulses, `cnt` returns to 0.
- N=8, QUAL=5, SYNC_STAGES=0, INVERT=1; reset → `y`=1. Drive `in`=8'hFF with `en` toggling 1,0,1,0… → `y` drops after the 5th enabled edge, `y_rise`=1 that cycle.
- Defaults; `in`=3'b111, assert `rst_n`=0 after 4 edges (mid-count) for 2 cycles, then release → `y`=0 and no pulse during reset. `y` rises 6 edges after release: sync flops refill (2 edges) plus QUAL (4 edges).
- QUAL=1, SYNC_STAGES=0; `in` alternates 111/000 every cycle → `y` follows with 1-cycle delay, `y_rise`/`y_fall` alternate, each one cycle wide.
